// File: rtl/tag_flag_ram_ro_256.sv
// tag_flag_ram_ro_256
//   Tag and valid-flag store for one way of a 256-set read-only cache.
//   Every non-reset cycle the set at Index is read into output registers.
//   The registered tag is compared against the live Tag_Cmp, which is
//   intended to be stable in the next pipeline stage (TLB output).
//   Writes are write-first: written data shows on the outputs at the same edge.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset; clears all valid flags
//   Index      in   [7:0]  set select for read and write
//   Tag_Cmp    in   [TW-1:0] tag compared against the registered stored tag
//   Tag_Set    in   [TW-1:0] tag written when Write=1
//   Write      in   write enable for the set at Index
//   Valid      in   valid flag written when Write=1
//   MatchHit   out  registered valid AND (registered tag == Tag_Cmp)
//   MatchValid out  valid flag of the entry read at the last edge
//
// Optional build macro TAGFLAG_PARITY_EN: stores an even-parity bit with each
// tag; a parity mismatch on the read tag forces MatchValid and MatchHit to 0.

module tag_flag_ram_ro_256 #(
    parameter int unsigned PABITS = 36
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           Index,
    input  logic [PABITS-13:0]   Tag_Cmp,
    input  logic [PABITS-13:0]   Tag_Set,
    input  logic                 Write,
    input  logic                 Valid,
    output logic                 MatchHit,
    output logic                 MatchValid
);

    localparam int unsigned TW = PABITS - 12;

`ifdef TAGFLAG_PARITY_EN
    localparam int unsigned EW = TW + 1;  // tag plus even-parity bit in the MSB
`else
    localparam int unsigned EW = TW;
`endif

    // Tag array: no reset so it can map onto block RAM.
    logic [EW-1:0] r_tag_mem [256];
    // Valid flags kept in flops so reset can clear every set at once.
    logic [255:0]  r_valid;

    logic [EW-1:0] r_rd_entry;
    logic          r_rd_valid;

    logic [EW-1:0] w_wr_entry;
    logic [TW-1:0] w_rd_tag;
    logic          w_entry_ok;

`ifdef TAGFLAG_PARITY_EN
    assign w_wr_entry = {^Tag_Set, Tag_Set};
    assign w_rd_tag   = r_rd_entry[TW-1:0];
    // Even parity: XOR over tag and stored parity bit must be zero.
    assign w_entry_ok = ~(^r_rd_entry);
`else
    assign w_wr_entry = Tag_Set;
    assign w_rd_tag   = r_rd_entry;
    assign w_entry_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!reset && Write) begin
            r_tag_mem[Index] <= w_wr_entry;
        end
    end

    // Read register for the tag; left untouched by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_entry <= Write ? w_wr_entry : r_tag_mem[Index];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (Write) begin
                r_valid[Index] <= Valid;
            end
            r_rd_valid <= Write ? Valid : r_valid[Index];
        end
    end

    // rd_valid gates the compare, so an unwritten (unknown) tag cannot leak out.
    always_comb begin
        MatchValid = r_rd_valid & w_entry_ok;
        MatchHit   = MatchValid & (w_rd_tag == Tag_Cmp);
    end

endmodule

// File: tb/tb_tag_flag_ram_ro_256.sv
// Testbench for tag_flag_ram_ro_256: directed vectors driven on the falling
// edge, expected outputs queued per cycle and checked by a separate monitor
// just after each rising edge.

module tb_tag_flag_ram_ro_256;

    localparam int unsigned PABITS = 36;
    localparam int unsigned TW     = PABITS - 12;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    Index;
    logic [TW-1:0] Tag_Cmp;
    logic [TW-1:0] Tag_Set;
    logic          Write;
    logic          Valid;
    logic          MatchHit;
    logic          MatchValid;

    always #5 clock = ~clock;

    tag_flag_ram_ro_256 #(
        .PABITS (PABITS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .Index      (Index),
        .Tag_Cmp    (Tag_Cmp),
        .Tag_Set    (Tag_Set),
        .Write      (Write),
        .Valid      (Valid),
        .MatchHit   (MatchHit),
        .MatchValid (MatchValid)
    );

    typedef struct {
        bit    chk;
        bit    ev;
        bit    eh;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // One queue entry per driven cycle; the monitor pops one per rising edge.
    task automatic drive(input bit rst, input logic [7:0] idx, input logic [TW-1:0] cmp,
                         input logic [TW-1:0] tset, input bit wr, input bit v,
                         input bit chk, input bit ev, input bit eh, input string name);
        exp_t e;
        @(negedge clock);
        reset   = rst;
        Index   = idx;
        Tag_Cmp = cmp;
        Tag_Set = tset;
        Write   = wr;
        Valid   = v;
        e.chk   = chk;
        e.ev    = ev;
        e.eh    = eh;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // Read (no write) with check.
    task automatic rd(input logic [7:0] idx, input logic [TW-1:0] cmp,
                      input bit ev, input bit eh, input string name);
        drive(1'b0, idx, cmp, 24'h0, 1'b0, 1'b0, 1'b1, ev, eh, name);
    endtask

    // Write with check of the write-first outputs.
    task automatic wr(input logic [7:0] idx, input logic [TW-1:0] cmp, input logic [TW-1:0] tset,
                      input bit v, input bit ev, input bit eh, input string name);
        drive(1'b0, idx, cmp, tset, 1'b1, v, 1'b1, ev, eh, name);
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                checks++;
                if (MatchValid !== e.ev || MatchHit !== e.eh) begin
                    errors++;
                    $display("FAIL %s: got valid=%b hit=%b, expected valid=%b hit=%b",
                             e.name, MatchValid, MatchHit, e.ev, e.eh);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        Index   = 8'h00;
        Tag_Cmp = '0;
        Tag_Set = '0;
        Write   = 1'b0;
        Valid   = 1'b0;

        // Reset, including a write that must be ignored.
        drive(1'b1, 8'h00, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset");
        drive(1'b1, 8'h50, 24'h0A0A0A, 24'h0A0A0A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "reset_wr");
        rd(8'h70, 24'h000000, 1'b0, 1'b0, "post_reset_70");
        rd(8'h71, 24'hFFFFFF, 1'b0, 1'b0, "post_reset_71");
        rd(8'h72, 24'h123456, 1'b0, 1'b0, "post_reset_72");
        rd(8'h50, 24'h0A0A0A, 1'b0, 1'b0, "wr_ignored_in_reset");

        // Write-first hit, then plain read.
        wr(8'h03, 24'h123456, 24'h123456, 1'b1, 1'b1, 1'b1, "wf_hit_03");
        rd(8'h03, 24'h123456, 1'b1, 1'b1, "read_hit_03");

        // Writing Valid=0 invalidates.
        wr(8'h02, 24'h123456, 24'h123456, 1'b0, 1'b0, 1'b0, "wf_invalid_02");
        rd(8'h02, 24'h123456, 1'b0, 1'b0, "read_invalid_02");

        // Load entries; 0x11 written with a non-matching compare tag.
        wr(8'h11, 24'h000000, 24'h333333, 1'b1, 1'b1, 1'b0, "wf_miss_11");
        wr(8'hCD, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1, 1'b1, "wf_hit_cd");
        wr(8'hEE, 24'h000001, 24'h000001, 1'b1, 1'b1, 1'b1, "wf_hit_ee");

        rd(8'h11, 24'h333333, 1'b1, 1'b1, "hit_11");
        rd(8'h11, 24'h123456, 1'b1, 1'b0, "miss_11");
        rd(8'h11, 24'hB33333, 1'b1, 1'b0, "miss_11_msb");
        rd(8'h11, 24'h333332, 1'b1, 1'b0, "miss_11_lsb");
        rd(8'hEE, 24'hFFFFFF, 1'b1, 1'b0, "miss_ee");
        rd(8'hCD, 24'hFFFFFF, 1'b1, 1'b1, "hit_cd");

        // Back-to-back sequence.
        rd(8'hAA, 24'h000000, 1'b0, 1'b0, "b2b_invalid_aa");
        rd(8'h11, 24'h333333, 1'b1, 1'b1, "b2b_hit_11");
        rd(8'hEE, 24'hFFFFFF, 1'b1, 1'b0, "b2b_miss_ee");

        // Index boundaries.
        wr(8'hFF, 24'h000000, 24'hABCDEF, 1'b1, 1'b1, 1'b0, "wf_ff");
        rd(8'h00, 24'hABCDEF, 1'b0, 1'b0, "read_00_unwritten");
        rd(8'hFF, 24'hABCDEF, 1'b1, 1'b1, "read_ff");
        rd(8'h03, 24'h123456, 1'b1, 1'b1, "read_03_kept");

        // Mid-operation reset with a pending write that must be dropped.
        drive(1'b1, 8'h03, 24'h123456, 24'h123456, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "mid_reset");
        rd(8'h03, 24'h123456, 1'b0, 1'b0, "after_reset_03");
        rd(8'h11, 24'h333333, 1'b0, 1'b0, "after_reset_11");
        rd(8'hFF, 24'hABCDEF, 1'b0, 1'b0, "after_reset_ff");

        // Recovery after reset.
        wr(8'h03, 24'h654321, 24'h654321, 1'b1, 1'b1, 1'b1, "rewrite_03");
        rd(8'h03, 24'h654321, 1'b1, 1'b1, "reread_03");
        rd(8'h03, 24'h123456, 1'b1, 1'b0, "reread_03_old_tag");

        drive(1'b0, 8'h00, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #2;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tag_flag_ram_ro_256.md
Name: tag_flag_ram_ro_256

Overview:
- Tag and valid-flag store for one way of a 256-set read-only (instruction) cache; no dirty flag.
- Holds a tag of PABITS-12 bits plus one valid bit per set.
- Each cycle: the set at Index is read synchronously, then its stored tag is compared with the physical tag presented on Tag_Cmp.
- Writes are write-first: a written entry appears on the outputs in the same clock edge.

Parameters:
- PABITS, 36, physical address width. Tag width TW = PABITS-12; 24 at default.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Index  in  8  set select for read and write.
- Tag_Cmp  in  TW  tag compared against the registered stored tag.
- Tag_Set  in  TW  tag written when Write=1.
- Write  in  1  write enable for the set at Index.
- Valid  in  1  valid flag written when Write=1.
- MatchHit  out  1  registered valid AND (registered tag == Tag_Cmp).
- MatchValid  out  1  valid flag of the entry read at the last edge.

Behaviour:
- Storage:
  - Tags: 256 x TW array, inferable as block RAM, never reset.
  - Valid flags: 256 discrete flops, so reset can clear them all.
- Read: on each rising edge with reset=0, capture tag[Index] and valid[Index] into output registers rd_tag and rd_valid. Read latency is 1 edge.
- Write: on a rising edge with Write=1 and reset=0:
  - tag[Index] <= Tag_Set and valid[Index] <= Valid.
  - Write-first: rd_tag <= Tag_Set and rd_valid <= Valid on the same edge.
- MatchValid = rd_valid.
- MatchHit = rd_valid & (rd_tag == Tag_Cmp), combinational against the live Tag_Cmp.
  - The compare is intended for the next pipeline stage, where Tag_Cmp (TLB output) is stable.
  - Full TW-bit equality is required.
- Reset (synchronous): on a rising edge with reset=1:
  - All 256 valid flags clear to 0, and rd_valid clears to 0.
  - Write is ignored.
  - Tag contents and rd_tag are unchanged or don't-care.
  - After reset: MatchValid=0 and MatchHit=0.
- Reset asserted mid-operation has the same effect on the next edge; any pending write that cycle is dropped.
- Index wraps naturally; all 256 sets are valid addresses (0x00-0xFF).
- Writing Valid=0 invalidates the set; MatchHit=0 thereafter regardless of tag.
- Write=0 leaves the storage untouched; a read occurs every non-reset cycle.
- No X may reach the outputs after the first reset, including for sets never written.

Optional Feature:
- Macro TAGFLAG_PARITY_EN.
- When defined:
  - Each tag entry stores an extra even-parity bit computed from Tag_Set on write.
  - On read, parity is recomputed over rd_tag.
  - On mismatch, MatchValid and MatchHit are forced to 0, turning a corrupted entry into a miss and refill.
- When undefined: no parity bit is stored and the outputs follow the base behaviour.
- The port list is identical in both builds.

Test Plan:
- Reset, then Index=0x70/0x71/0x72 with any Tag_Cmp -> MatchValid=0 and MatchHit=0 on each cycle.
- Write Index=0x03, Tag_Set=0x123456, Valid=1, Tag_Cmp=0x123456 -> immediately after the edge MatchValid=1, MatchHit=1 (write-first). Next cycle with Write=0 -> still 1/1.
- Write Index=0x02, tag 0x123456, Valid=0 -> MatchValid=0, MatchHit=0 both on the write edge and on the following read.
- After writing 0x11={0x333333,v} and 0xCD={0xFFFFFF,v}:
  - Tag_Cmp=0x333333 at Index 0x11 -> hit=1, valid=1.
  - Tag_Cmp=0x123456 at Index 0x11 -> hit=0, valid=1.
  - Tag_Cmp=0xFFFFFF at Index 0xEE (holding {0x000001,v}) -> hit=0, valid=1.
- Back-to-back sequence: invalid miss at 0xAA, then hit at 0x11, then valid miss at 0xEE -> outputs 0/0, 1/1, 0/1 on consecutive edges.
- Assert reset after the entries are loaded, then re-read 0x03 with matching tag -> MatchValid=0, MatchHit=0.
